serial_scan_ctrl: RTL and testbench
===================================

SERIAL_SCAN_CTRL -- requirements
Module: serial_scan_ctrl

Interface
REQ-001 Parameter W, default 8: word width scanned per job; legal range 3..32.
REQ-002 Parameter CW, default 4: match-counter width; legal range 2..8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 clear_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  job request; accepted only when ready=1.
REQ-006 abort  input  1  cancels a job in progress.
REQ-007 data_in  input  W  word to serialize; sampled on accepted start.
REQ-008 pattern  input  3  3-bit target pattern, first-received bit in [2]; sampled on accepted start.
REQ-009 ready  output  1  high in IDLE only.
REQ-010 busy  output  1  high in SHIFT only.
REQ-011 x_ser  output  1  current serial bit; 0 outside SHIFT.
REQ-012 z  output  1  Mealy detect flag for the current x_ser bit.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 match_cnt  output  CW  detections in the current/last job.
REQ-015 state  output  2  FSM state code, debug only.

Function
REQ-016 FSM shall have states IDLE=00, SHIFT=01, DONE=10; code 11 shall return to IDLE on the next edge.
REQ-017 IDLE: start=1 at edge -> load shift register with data_in, latch pattern, clear match_cnt, clear the 2-bit history and bit index, go to SHIFT.
REQ-018 SHIFT shall last exactly W cycles; x_ser = shift-register MSB; register shifts left by one each cycle; data_in MSB is sent first.
REQ-019 History shall hold the previous two x_ser bits of the current job; the bit index shall count bits emitted (0..W-1).
REQ-020 z = 1 iff busy, index>=2, and {hist[1], hist[0], x_ser} == latched pattern; detection shall be overlapping (history not cleared on a match).
REQ-021 match_cnt shall increment on each edge where z=1 and shall saturate at 2^CW-1.
REQ-022 After the edge that consumes bit index W-1, go to DONE; DONE shall assert done=1 for exactly one cycle, then return to IDLE.
REQ-023 Timing: start accepted at edge 0 -> bits on cycles 1..W -> done on cycle W+1 -> ready on cycle W+2.
REQ-024 start while ready=0 shall be ignored and not queued.
REQ-025 abort=1 in SHIFT shall go to IDLE next edge, with no done pulse; match_cnt holds its value at abort.
REQ-026 abort in IDLE or DONE shall have no effect; abort and start together in IDLE: start wins.
REQ-027 A z=1 in the same cycle as abort shall still be counted.
REQ-028 match_cnt shall hold its value in DONE and IDLE until the next accepted start.
REQ-029 data_in and pattern changes after acceptance shall not affect the running job.

Reset
REQ-030 clear_n=0 at an edge shall, regardless of state (including mid-SHIFT), force IDLE, ready=1, busy=0, done=0, x_ser=0, z=0, match_cnt=0, state=00, and clear the shift register, history and index.
REQ-031 clear_n=0 shall take priority over start and abort; no done pulse shall follow a reset.
REQ-032 A start presented in the first cycle with clear_n=1 shall be accepted.

Verification
REQ-033 W=8, data_in=8'b10101101, pattern=3'b101 -> x_ser 1,0,1,0,1,1,0,1; z high on bits 3,5,8; match_cnt=3; done on cycle 9.
REQ-034 W=8, CW=2, data_in=8'hFF, pattern=3'b111 -> z high on bits 3..8; match_cnt saturates at 3.
REQ-035 data_in=8'h00, pattern=3'b101 -> z never high, match_cnt=0, done still pulses on cycle 9.
REQ-036 start at cycle 0, abort on cycle 4 -> IDLE on cycle 5, no done; second start on cycle 3 ignored.
REQ-037 clear_n=0 on cycle 5 of a job -> next cycle all outputs at reset values; a new start then completes normally.

Source files
------------

// File: rtl/serial_scan_ctrl.sv
// serial_scan_ctrl
//
// Accepts a W-bit word and a 3-bit target pattern, then serializes the word
// MSB-first over exactly W cycles while a Mealy detector flags every
// (overlapping) occurrence of the pattern in the emitted bit stream.
// Detections are counted in a saturating counter. A one-cycle done pulse
// follows a completed job. Abort cancels a running job without a done pulse.
//
// Ports
//   clk        sole clock, rising edge
//   clear_n    synchronous active-low reset
//   start      job request, accepted only while ready=1
//   abort      cancels a job in SHIFT (ignored elsewhere)
//   data_in    word to serialize, sampled on accepted start
//   pattern    target pattern, first-received bit in [2], sampled on start
//   ready      high in IDLE
//   busy       high in SHIFT
//   x_ser      current serial bit, 0 outside SHIFT
//   z          Mealy detect flag for the current x_ser bit
//   done       one-cycle completion pulse
//   match_cnt  detections in the current/last job (saturating)
//   state      FSM state code (debug)
module serial_scan_ctrl #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          clear_n,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  data_in,
    input  logic [2:0]    pattern,
    output logic          ready,
    output logic          busy,
    output logic          x_ser,
    output logic          z,
    output logic          done,
    output logic [CW-1:0] match_cnt,
    output logic [1:0]    state
);

    localparam int IW = $clog2(W);
    localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10,
        S_BAD   = 2'b11
    } state_t;

    state_t        cur_state;
    state_t        nxt_state;
    logic [W-1:0]  shreg;
    logic [1:0]    hist;      // hist[1] = older bit, hist[0] = previous bit
    logic [IW-1:0] idx;       // index of the bit currently on x_ser
    logic [2:0]    pat;

    // Counter sticks at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!clear_n)
            cur_state <= S_IDLE;
        else
            cur_state <= nxt_state;
    end

    // Next-state logic
    always_comb begin
        nxt_state = S_IDLE;
        case (cur_state)
            S_IDLE:  nxt_state = start ? S_SHIFT : S_IDLE;
            S_SHIFT: begin
                if (abort)
                    nxt_state = S_IDLE;
                else if (idx == LAST_IDX)
                    nxt_state = S_DONE;
                else
                    nxt_state = S_SHIFT;
            end
            S_DONE:  nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;  // unused code 11 recovers to IDLE
        endcase
    end

    // Output logic
    always_comb begin
        ready = (cur_state == S_IDLE);
        busy  = (cur_state == S_SHIFT);
        done  = (cur_state == S_DONE);
        state = cur_state;
        x_ser = busy & shreg[W-1];
        // Detection needs two earlier bits of this job in the history.
        z     = busy && (idx >= IW'(2)) && ({hist, x_ser} == pat);
    end

    // Shift register, history, bit index and match counter
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            shreg     <= '0;
            hist      <= '0;
            idx       <= '0;
            pat       <= '0;
            match_cnt <= '0;
        end else begin
            case (cur_state)
                S_IDLE: begin
                    if (start) begin
                        shreg     <= data_in;
                        pat       <= pattern;
                        hist      <= '0;
                        idx       <= '0;
                        match_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    // Updates continue on an abort edge so a detection in
                    // that final cycle is still counted.
                    shreg <= {shreg[W-2:0], 1'b0};
                    hist  <= {hist[0], x_ser};
                    idx   <= idx + IW'(1);
                    if (z)
                        match_cnt <= sat_inc(match_cnt);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_scan_ctrl.sv
module tb_serial_scan_ctrl;

    localparam int W    = 8;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          clear_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic [2:0]    pattern = '0;
    logic          ready, busy, x_ser, z, done;
    logic [CW-1:0] match_cnt;
    logic [1:0]    state;

    serial_scan_ctrl #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .start     (start),
        .abort     (abort),
        .data_in   (data_in),
        .pattern   (pattern),
        .ready     (ready),
        .busy      (busy),
        .x_ser     (x_ser),
        .z         (z),
        .done      (done),
        .match_cnt (match_cnt),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          nb;          // bits expected on x_ser
        logic [31:0] xb;          // expected bit i of the stream at [i]
        logic [31:0] zb;          // expected z for bit i at [i]
        int          cnt;         // expected match_cnt once the job ends
        bit          ends_done;   // job ends with a done pulse
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: stream is the word MSB-first; a hit is any position i>=2
    // whose last three stream bits equal the pattern; count saturates.
    function automatic exp_t model(input logic [W-1:0] d, input logic [2:0] p,
                                   input int stop, input bit by_reset);
        exp_t e;
        logic [W-1:0] b;
        int n;
        int cnt;
        n = (stop > 0) ? stop : W;
        e.xb = '0;
        e.zb = '0;
        b = '0;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            b[i] = d[W-1-i];
            e.xb[i] = b[i];
            if (i >= 2 && {b[i-2], b[i-1], b[i]} == p) begin
                e.zb[i] = 1'b1;
                cnt++;
            end
        end
        e.nb = n;
        e.cnt = by_reset ? 0 : ((cnt > CMAX) ? CMAX : cnt);
        e.ends_done = (stop == 0);
        return e;
    endfunction

    // Monitor: collects each busy burst and scores it when the job ends.
    initial begin
        bit pb;
        bit pd;
        int nb;
        logic [31:0] xb;
        logic [31:0] zb;
        exp_t e;
        pb = 0;
        pd = 0;
        nb = 0;
        xb = '0;
        zb = '0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                if (!pb) begin
                    check("job_expected", 32'(q.size() > 0), 32'd1);
                    nb = 0;
                    xb = '0;
                    zb = '0;
                end
                if (nb < 32) begin
                    xb[nb] = x_ser;
                    zb[nb] = z;
                end
                nb++;
            end else begin
                check("idle_x_ser", 32'(x_ser), 32'd0);
                check("idle_z", 32'(z), 32'd0);
                if (pb) begin
                    if (q.size() == 0) begin
                        check("job_end_has_expectation", 32'd0, 32'd1);
                    end else begin
                        e = q.pop_front();
                        check("bit_count", 32'(nb), 32'(e.nb));
                        check("x_ser_bits", xb, e.xb);
                        check("z_bits", zb, e.zb);
                        check("match_cnt", 32'(match_cnt), 32'(e.cnt));
                        check("done_at_end", 32'(done), 32'(e.ends_done));
                    end
                end
                if (pd) begin
                    check("done_one_cycle", 32'(done), 32'd0);
                    check("ready_after_done", 32'(ready), 32'd1);
                end
            end
            pb = (busy === 1'b1);
            pd = (done === 1'b1);
        end
    end

    // One job: optional abort/reset in bit cycle 1..W, optional stray start.
    task automatic run_job(input logic [W-1:0] d, input logic [2:0] p,
                           input int abort_at, input int reset_at,
                           input int ign_at, input bit abort_with_start);
        int guard;
        int stop;
        bit ended;
        guard = 0;
        ended = 0;
        while (ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_before_start", 32'(ready), 32'd1);
        stop = (reset_at > 0) ? reset_at : abort_at;
        q.push_back(model(d, p, stop, reset_at > 0));
        start = 1'b1;
        data_in = d;
        pattern = p;
        abort = abort_with_start;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        data_in = W'($urandom);
        pattern = 3'($urandom);
        for (int c = 1; c <= W; c++) begin
            if (c == abort_at) abort = 1'b1;
            if (c == reset_at) clear_n = 1'b0;
            if (c == ign_at)   start = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            start = 1'b0;
            if (c == reset_at) begin
                clear_n = 1'b1;
                check("rst_ready", 32'(ready), 32'd1);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_x_ser", 32'(x_ser), 32'd0);
                check("rst_z", 32'(z), 32'd0);
                check("rst_match_cnt", 32'(match_cnt), 32'd0);
                check("rst_state", 32'(state), 32'd0);
                ended = 1;
                break;
            end
            if (c == abort_at) begin
                check("abort_to_idle", 32'(state), 32'd0);
                check("abort_no_done", 32'(done), 32'd0);
                ended = 1;
                break;
            end
        end
        if (!ended) begin
            check("done_cycle_w_plus_1", 32'(done), 32'd1);
            check("done_state", 32'(state), 32'd2);
            @(posedge clk); #1;
            check("ready_cycle_w_plus_2", 32'(ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        int gap;
        int mode;
        int ab;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_x_ser", 32'(x_ser), 32'd0);
        check("reset_z", 32'(z), 32'd0);
        check("reset_match_cnt", 32'(match_cnt), 32'd0);
        check("reset_state", 32'(state), 32'd0);

        // Start in the very first cycle out of reset.
        clear_n = 1'b1;
        run_job(8'b10101101, 3'b101, 0, 0, 0, 0);
        run_job(8'hFF, 3'b111, 0, 0, 0, 0);
        run_job(8'h00, 3'b101, 0, 0, 0, 0);
        run_job(8'b11011011, 3'b110, 4, 0, 3, 0);
        run_job(8'b10110110, 3'b011, 0, 5, 0, 0);
        run_job(8'b01101101, 3'b101, 0, 0, 0, 0);
        run_job(8'b11100111, 3'b111, 0, 0, 0, 1);
        run_job(8'hFF, 3'b111, W, 0, 0, 0);
        run_job(8'b10101010, 3'b010, 3, 0, 0, 0);

        for (int j = 0; j < 40; j++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                abort = 1'($urandom);
                @(posedge clk); #1;
                abort = 1'b0;
                check("idle_holds", 32'(ready), 32'd1);
            end
            mode = $urandom_range(0, 9);
            ab = $urandom_range(1, W);
            run_job(W'($urandom), 3'($urandom),
                    (mode < 3) ? ab : 0,
                    (mode == 3) ? ab : 0,
                    (mode > 5) ? $urandom_range(1, W) : 0,
                    1'($urandom));
        end

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
